wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and register width.
REQ-002 SHALL have parameter NREG, default 16, meaning number of architectural GPRs; legal values 16 (RV32E) or 32 (RV32I).
REQ-003 SHALL have parameter NRP, default 2, meaning number of combinational read ports; legal range 1..4.
REQ-004 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning PC value held in reset.
REQ-005 SHALL have port sys_clk, input, 1, meaning clock, rising edge.
REQ-006 SHALL have port sys_rst, input, 1, meaning reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1, meaning write-back transaction offered.
REQ-008 SHALL have port in_ready, output, 1, meaning block accepts the transaction; a handshake occurs when in_valid and in_ready are both high.
REQ-009 SHALL have port in_rd, input, 5, meaning destination GPR index.
REQ-010 SHALL have port in_rd_wen, input, 1, meaning GPR write request.
REQ-011 SHALL have port in_rd_wdata, input, XLEN, meaning GPR write data.
REQ-012 SHALL have port in_pc_wen, input, 1, meaning redirect; when low, next PC is PC+4.
REQ-013 SHALL have port in_pc_wdata, input, XLEN, meaning redirect target.
REQ-014 SHALL have port raddr, input, NRP x 5, meaning read-port indices.
REQ-015 SHALL have port rdata, output, NRP x XLEN, meaning read-port data.
REQ-016 SHALL have port pc, output, XLEN, meaning current architectural PC (registered).
REQ-017 SHALL have port commit_valid, output, 1, meaning one-cycle pulse per retired instruction.
REQ-018 SHALL have port commit_pc, output, XLEN, meaning PC of the retired instruction.
REQ-019 SHALL have port retire_cnt, output, 64, meaning retired-instruction count.

Function
REQ-020 SHALL implement FSM states BOOT and RUN; BOOT is entered on reset, and RUN is entered on the first sys_clk edge after sys_rst deasserts and is held until the next reset.
REQ-021 SHALL drive in_ready low in BOOT and high in RUN.
REQ-022 SHALL, on a handshake, write in_rd_wdata to GPR in_rd at that clock edge when in_rd_wen=1, in_rd!=0 and in_rd<NREG; otherwise no GPR changes.
REQ-023 SHALL return 0 for reads of index 0 and of any index >= NREG, and SHALL ignore writes to those indices.
REQ-024 SHALL, on a handshake, update pc at that edge to in_pc_wdata if in_pc_wen=1, else to pc+4 modulo 2^XLEN; without a handshake pc SHALL hold.
REQ-025 SHALL assert commit_valid for exactly one cycle after each handshake, with commit_pc equal to pc before the update; commit_pc SHALL hold its last value otherwise.
REQ-026 SHALL increment retire_cnt by 1 on each handshake, wrapping from 2^64-1 to 0.
REQ-027 SHALL read all NRP ports combinationally and independently; multiple ports SHALL be allowed to name the same index.
REQ-028 SHALL accept back-to-back handshakes on consecutive cycles with no bubble (throughput 1 per cycle).
REQ-029 SHALL ignore all in_* inputs while in BOOT, even if in_valid=1.

Reset
REQ-030 SHALL, while sys_rst=1, force all GPRs to 0, pc=RESET_PC, commit_valid=0, commit_pc=0, retire_cnt=0, FSM=BOOT, in_ready=0.
REQ-031 SHALL, when sys_rst is asserted mid-operation, abort any in-flight handshake with no GPR, pc or counter update and no commit pulse.

Configuration
REQ-032 SHALL, with macro WB_REGFILE_BYPASS_EN defined, drive rdata[k] = in_rd_wdata on any cycle with a handshake where in_rd_wen=1, in_rd!=0, in_rd<NREG and raddr[k]==in_rd (write-to-read forwarding in the same cycle).
REQ-033 SHALL, without WB_REGFILE_BYPASS_EN, return only the stored register value, so a same-cycle write becomes visible on the next cycle.

Verification
REQ-034 SHALL verify reset: assert sys_rst, then release -> pc=32'h8000_0000, retire_cnt=0, in_ready=0 for one cycle then 1.
REQ-035 SHALL verify sequential retire: 3 handshakes with in_pc_wen=0 -> pc=32'h8000_000C, retire_cnt=3, commit_pc = 80000000/04/08 on consecutive cycles.
REQ-036 SHALL verify redirect: handshake with in_pc_wen=1, in_pc_wdata=32'h8000_0100 -> pc=32'h8000_0100 next cycle, commit_pc=prior pc.
REQ-037 SHALL verify x0 and range: write 32'hDEADBEEF to index 0, then to index 20 with NREG=16 -> rdata=0 for both; with NREG=32, index 20 reads 32'hDEADBEEF.
REQ-038 SHALL verify bypass: same-cycle write 32'h1234 to index 5 while raddr[0]=5 -> rdata[0]=32'h1234 with the macro defined, old value without it.
REQ-039 SHALL verify reset mid-stream: assert sys_rst during a handshake with in_valid=1 -> no commit pulse, GPRs=0, pc=RESET_PC.

Source files
------------

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Brief    : Write-back stage with the GPR file, architectural PC and retire
//            counter. Optional same-cycle write-to-read forwarding when
//            WB_REGFILE_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 16,
  parameter int              NRP      = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4:0]                in_rd,
  input  logic                      in_rd_wen,
  input  logic [XLEN-1:0]           in_rd_wdata,
  input  logic                      in_pc_wen,
  input  logic [XLEN-1:0]           in_pc_wdata,
  input  logic [NRP-1:0][4:0]       raddr,
  output logic [NRP-1:0][XLEN-1:0]  rdata,
  output logic [XLEN-1:0]           pc,
  output logic                      commit_valid,
  output logic [XLEN-1:0]           commit_pc,
  output logic [63:0]               retire_cnt
);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    gpr_q [NREG];
  logic [XLEN-1:0]    gpr_d [NREG];
  logic [XLEN-1:0]    pc_q, pc_d;
  logic               commit_valid_q, commit_valid_d;
  logic [XLEN-1:0]    commit_pc_q, commit_pc_d;
  logic [63:0]        retire_cnt_q, retire_cnt_d;

  logic               w_hs;
  logic               w_wr_en;

  assign in_ready = (state_q == ST_RUN);
  assign w_hs     = in_valid & in_ready;
  // Index 0 and out-of-range indices are never written.
  assign w_wr_en  = w_hs & in_rd_wen & (in_rd != 5'd0) & ({1'b0, in_rd} < 6'(NREG));

  always_comb begin
    state_d        = ST_RUN;
    gpr_d          = gpr_q;
    pc_d           = pc_q;
    commit_valid_d = w_hs;
    commit_pc_d    = commit_pc_q;
    retire_cnt_d   = retire_cnt_q;
    if (w_hs) begin
      commit_pc_d  = pc_q;
      pc_d         = in_pc_wen ? in_pc_wdata : pc_q + XLEN'(4);
      retire_cnt_d = retire_cnt_q + 64'd1;
    end
    for (int i = 1; i < NREG; i++) begin
      if (w_wr_en && (in_rd == 5'(i))) begin
        gpr_d[i] = in_rd_wdata;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q        <= ST_BOOT;
      gpr_q          <= '{default: '0};
      pc_q           <= RESET_PC;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      retire_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      gpr_q          <= gpr_d;
      pc_q           <= pc_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      retire_cnt_q   <= retire_cnt_d;
    end
  end

  assign pc           = pc_q;
  assign commit_valid = commit_valid_q;
  assign commit_pc    = commit_pc_q;
  assign retire_cnt   = retire_cnt_q;

  generate
    for (genvar k = 0; k < NRP; k++) begin : g_rd_port
      logic [XLEN-1:0] rd_val;
      always_comb begin
        rd_val = '0;
        for (int i = 1; i < NREG; i++) begin
          if (raddr[k] == 5'(i)) begin
            rd_val = gpr_q[i];
          end
        end
`ifdef WB_REGFILE_BYPASS_EN
        if (w_wr_en && (raddr[k] == in_rd)) begin
          rd_val = in_rd_wdata;
        end
`endif
      end
      assign rdata[k] = rd_val;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Brief    : Self-checking bench: directed vector table, corner sequences and
//            random traffic against an array-based architectural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready, in_ready32;
  logic [4:0]       in_rd = '0;
  logic             in_rd_wen = 1'b0;
  logic [31:0]      in_rd_wdata = '0;
  logic             in_pc_wen = 1'b0;
  logic [31:0]      in_pc_wdata = '0;
  logic [1:0][4:0]  raddr = '0;
  logic [1:0][31:0] rdata, rdata32;
  logic [31:0]      pc, pc32, commit_pc, commit_pc32;
  logic             commit_valid, commit_valid32;
  logic [63:0]      retire_cnt, retire_cnt32;

  always #5 clk = ~clk;

  wb_regfile #(.XLEN(32), .NREG(16), .NRP(2), .RESET_PC(RST_PC)) dut (
    .sys_clk(clk), .sys_rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_rd_wdata(in_rd_wdata),
    .in_pc_wen(in_pc_wen), .in_pc_wdata(in_pc_wdata), .raddr(raddr),
    .rdata(rdata), .pc(pc), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .retire_cnt(retire_cnt));

  wb_regfile #(.XLEN(32), .NREG(32), .NRP(2), .RESET_PC(RST_PC)) dut32 (
    .sys_clk(clk), .sys_rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_rd_wdata(in_rd_wdata),
    .in_pc_wen(in_pc_wen), .in_pc_wdata(in_pc_wdata), .raddr(raddr),
    .rdata(rdata32), .pc(pc32), .commit_valid(commit_valid32),
    .commit_pc(commit_pc32), .retire_cnt(retire_cnt32));

  // Architectural model
  logic [31:0] m_gpr16 [32];
  logic [31:0] m_gpr32 [32];
  logic [31:0] m_pc, m_cpc;
  logic [63:0] m_cnt;
  logic        m_cv, m_ready;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_gpr16[i] = '0;
      m_gpr32[i] = '0;
    end
    m_pc = RST_PC; m_cpc = '0; m_cnt = '0; m_cv = 1'b0; m_ready = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input bit big, input logic [4:0] idx);
    int nreg = big ? 32 : 16;
    if (idx == 0 || int'(idx) >= nreg) return '0;
    if (BYP && in_valid && m_ready && in_rd_wen && in_rd == idx) return in_rd_wdata;
    return big ? m_gpr32[idx] : m_gpr16[idx];
  endfunction

  // Inputs already driven just after an edge: check reads, clock, check state.
  task automatic step();
    bit hs;
    #2;
    chk("in_ready", {63'd0, in_ready}, {63'd0, m_ready});
    for (int k = 0; k < 2; k++) begin
      chk("rdata16", {32'd0, rdata[k]}, {32'd0, exp_rd(1'b0, raddr[k])});
      chk("rdata32", {32'd0, rdata32[k]}, {32'd0, exp_rd(1'b1, raddr[k])});
    end
    hs = in_valid && m_ready;
    @(posedge clk);
    #1;
    m_cv = hs;
    if (hs) begin
      if (in_rd_wen && in_rd != 0) begin
        if (in_rd < 16) m_gpr16[in_rd] = in_rd_wdata;
        m_gpr32[in_rd] = in_rd_wdata;
      end
      m_cpc = m_pc;
      m_pc  = in_pc_wen ? in_pc_wdata : m_pc + 32'd4;
      m_cnt = m_cnt + 64'd1;
    end
    m_ready = 1'b1;
    chk("pc", {32'd0, pc}, {32'd0, m_pc});
    chk("commit_valid", {63'd0, commit_valid}, {63'd0, m_cv});
    chk("commit_pc", {32'd0, commit_pc}, {32'd0, m_cpc});
    chk("retire_cnt", retire_cnt, m_cnt);
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic wen,
                       input logic [31:0] wd, input logic pwen, input logic [31:0] pwd);
    in_valid = v; in_rd = rd; in_rd_wen = wen; in_rd_wdata = wd;
    in_pc_wen = pwen; in_pc_wdata = pwd;
  endtask

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] wd;
    logic        pwen;
    logic [31:0] pwd;
    logic [31:0] e_pc;
    logic [63:0] e_cnt;
    logic        e_cv;
    logic [31:0] e_cpc;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{1'b1, 5'd1,  1'b1, 32'h1111_1111, 1'b0, 32'h0,         32'h8000_0004, 64'd1, 1'b1, 32'h8000_0000};
    vecs[1] = '{1'b1, 5'd2,  1'b1, 32'h2222_2222, 1'b0, 32'h0,         32'h8000_0008, 64'd2, 1'b1, 32'h8000_0004};
    vecs[2] = '{1'b1, 5'd0,  1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         32'h8000_000C, 64'd3, 1'b1, 32'h8000_0008};
    vecs[3] = '{1'b1, 5'd20, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h8000_0100, 32'h8000_0100, 64'd4, 1'b1, 32'h8000_000C};
    vecs[4] = '{1'b0, 5'd3,  1'b1, 32'h3333_3333, 1'b1, 32'h1234_5678, 32'h8000_0100, 64'd4, 1'b0, 32'h8000_000C};

    // Reset and boot cycle
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", {32'd0, pc}, {32'd0, RST_PC});
    chk("rst_cnt", retire_cnt, 64'd0);
    chk("rst_cv", {63'd0, commit_valid}, 64'd0);
    chk("rst_cpc", {32'd0, commit_pc}, 64'd0);
    rst = 1'b0;
    // Offered transaction during BOOT must be ignored
    drive(1'b1, 5'd3, 1'b1, 32'hBAD0_BAD0, 1'b1, 32'h0000_1000);
    #1;
    chk("boot_ready", {63'd0, in_ready}, 64'd0);
    step();
    chk("run_ready", {63'd0, in_ready}, 64'd1);
    chk("boot_ignored_pc", {32'd0, pc}, {32'd0, RST_PC});

    // Directed table: sequential retire, x0, out-of-range, redirect
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].v, vecs[i].rd, vecs[i].wen, vecs[i].wd, vecs[i].pwen, vecs[i].pwd);
      raddr[0] = 5'd0; raddr[1] = 5'd20;
      step();
      chk("vec_pc", {32'd0, pc}, {32'd0, vecs[i].e_pc});
      chk("vec_cnt", retire_cnt, vecs[i].e_cnt);
      chk("vec_cv", {63'd0, commit_valid}, {63'd0, vecs[i].e_cv});
      chk("vec_cpc", {32'd0, commit_pc}, {32'd0, vecs[i].e_cpc});
    end
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    raddr[0] = 5'd0; raddr[1] = 5'd20;
    #2;
    chk("x0_read", {32'd0, rdata[0]}, 64'd0);
    chk("idx20_nreg16", {32'd0, rdata[1]}, 64'd0);
    chk("idx20_nreg32", {32'd0, rdata32[1]}, 64'hDEAD_BEEF);
    raddr[0] = 5'd1; raddr[1] = 5'd1;
    #1;
    chk("dup_port0", {32'd0, rdata[0]}, 64'h1111_1111);
    chk("dup_port1", {32'd0, rdata[1]}, 64'h1111_1111);
    @(posedge clk); #1;

    // Same-cycle write/read of index 5
    drive(1'b1, 5'd5, 1'b1, 32'h0000_1234, 1'b0, 32'h0);
    raddr[0] = 5'd5; raddr[1] = 5'd2;
    #2;
    chk("bypass_rd", {32'd0, rdata[0]}, BYP ? 64'h1234 : 64'h0);
    #1;
    raddr[0] = 5'd5;
    step();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("after_write", {32'd0, rdata[0]}, 64'h1234);
    @(posedge clk); #1;

    // Random back-to-back traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 1'($urandom),
            $urandom, ($urandom_range(0, 3) == 0), $urandom);
      raddr[0] = 5'($urandom_range(0, 31));
      raddr[1] = ($urandom_range(0, 1) == 1) ? in_rd : 5'($urandom_range(0, 31));
      step();
    end

    // Reset asserted in the middle of a handshake
    drive(1'b1, 5'd1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0);
    raddr[0] = 5'd1; raddr[1] = 5'd5;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_cv", {63'd0, commit_valid}, 64'd0);
    chk("midrst_pc", {32'd0, pc}, {32'd0, RST_PC});
    @(posedge clk); #1;
    chk("midrst_cv2", {63'd0, commit_valid}, 64'd0);
    chk("midrst_pc2", {32'd0, pc}, {32'd0, RST_PC});
    chk("midrst_cnt", retire_cnt, 64'd0);
    chk("midrst_gpr1", {32'd0, rdata[0]}, 64'd0);
    chk("midrst_gpr5", {32'd0, rdata[1]}, 64'd0);
    chk("midrst_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    drive(1'b1, 5'd7, 1'b1, 32'h7777_7777, 1'b0, 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
